// File: rtl/tank_disp_ctrl.sv
// Frame-synchronous tank config controller and VGA pixel arbiter.
// Optional overlap detector enabled by defining TANK_COLLIDE_EN.
module tank_disp_ctrl #(
  parameter int N_TANK         = 4,
  parameter int PLAYER_SLOT_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [1:0]            upd_idx,
  input  logic [4:0]            upd_x,
  input  logic [4:0]            upd_y,
  input  logic [1:0]            upd_dir,
  input  logic                  upd_state,
  output logic [5*N_TANK-1:0]   tank_x_o,
  output logic [5*N_TANK-1:0]   tank_y_o,
  output logic [2*N_TANK-1:0]   tank_dir_o,
  output logic [N_TANK-1:0]     tank_state_o,
  output logic [N_TANK-1:0]     tank_ide_o,
  input  logic [N_TANK-1:0]     pix_en_i,
  input  logic [12*N_TANK-1:0]  pix_data_i,
  output logic [11:0]           VGA_data,
  output logic                  VGA_en,
`ifdef TANK_COLLIDE_EN
  output logic [N_TANK-1:0]     collide,
`endif
  output logic                  overrun
);

  typedef enum logic {
    S_IDLE,
    S_COMMIT
  } state_e;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [1:0] dir;
    logic       st;
  } ent_t;

  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       commit_en;
  logic       ovr_set;
  logic       xfer;

  ent_t                stg_q [N_TANK];
  logic [N_TANK-1:0]   dirty_q;
  logic [5*N_TANK-1:0] act_x_q;
  logic [5*N_TANK-1:0] act_y_q;
  logic [2*N_TANK-1:0] act_dir_q;
  logic [N_TANK-1:0]   act_st_q;
  logic                overrun_q;

  logic [11:0] pix_d, pix_q;
  logic        en_d, en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    upd_ready = 1'b0;
    commit_en = 1'b0;
    ovr_set   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        upd_ready = 1'b1;
        if (frame_tick) begin
          state_d = S_COMMIT;
          cnt_d   = '0;
        end
      end
      S_COMMIT: begin
        commit_en = 1'b1;
        ovr_set   = frame_tick;
        if (cnt_q == 2'(N_TANK-1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign xfer = upd_valid & upd_ready;

  // An out-of-range upd_idx matches no slot, so it is silently dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q     <= '{default: '0};
      dirty_q   <= '0;
      act_x_q   <= '0;
      act_y_q   <= '0;
      act_dir_q <= '0;
      act_st_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_TANK; i++) begin
        if (commit_en && cnt_q == 2'(i) && dirty_q[i]) begin
          act_x_q[5*i +: 5]   <= stg_q[i].x;
          act_y_q[5*i +: 5]   <= stg_q[i].y;
          act_dir_q[2*i +: 2] <= stg_q[i].dir;
          act_st_q[i]         <= stg_q[i].st;
          dirty_q[i]          <= 1'b0;
        end
        if (xfer && upd_idx == 2'(i)) begin
          stg_q[i]   <= '{x: upd_x, y: upd_y,
                          dir: upd_dir, st: upd_state};
          dirty_q[i] <= 1'b1;
        end
      end
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign tank_x_o     = act_x_q;
  assign tank_y_o     = act_y_q;
  assign tank_dir_o   = act_dir_q;
  assign tank_state_o = act_st_q;
  assign tank_ide_o   = (PLAYER_SLOT_EN != 0) ? N_TANK'(1) : '0;
  assign overrun      = overrun_q;

  // Scan high to low so the lowest enabled slot wins.
  always_comb begin
    pix_d = 12'h000;
    en_d  = 1'b0;
    for (int i = N_TANK-1; i >= 0; i--) begin
      if (pix_en_i[i]) begin
        pix_d = pix_data_i[12*i +: 12];
        en_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= 12'h000;
      en_q  <= 1'b0;
    end else begin
      pix_q <= pix_d;
      en_q  <= en_d;
    end
  end

  assign VGA_data = pix_q;
  assign VGA_en   = en_q;

`ifdef TANK_COLLIDE_EN
  logic              multi;
  logic [N_TANK-1:0] ovl;
  logic [N_TANK-1:0] acc_q;
  logic [N_TANK-1:0] col_q;

  // More than one bit set means every set bit is overlapping.
  assign multi = |(pix_en_i & (pix_en_i - N_TANK'(1)));
  assign ovl   = multi ? pix_en_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      col_q <= '0;
    end else if (frame_tick) begin
      col_q <= acc_q;
      acc_q <= ovl;
    end else begin
      acc_q <= acc_q | ovl;
    end
  end

  assign collide = col_q;
`endif

endmodule

// File: tb/tb_tank_disp_ctrl.sv
// Directed bench for tank_disp_ctrl with a pixel scoreboard.
// Define TANK_COLLIDE_EN to also exercise the overlap detector.
module tb_tank_disp_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_tick;
  logic          upd_valid;
  logic          upd_ready;
  logic [1:0]    upd_idx;
  logic [4:0]    upd_x;
  logic [4:0]    upd_y;
  logic [1:0]    upd_dir;
  logic          upd_state;
  logic [5*N-1:0]  tank_x_o;
  logic [5*N-1:0]  tank_y_o;
  logic [2*N-1:0]  tank_dir_o;
  logic [N-1:0]    tank_state_o;
  logic [N-1:0]    tank_ide_o;
  logic [N-1:0]    pix_en_i;
  logic [12*N-1:0] pix_data_i;
  logic [11:0]     VGA_data;
  logic            VGA_en;
  logic            overrun;
`ifdef TANK_COLLIDE_EN
  logic [N-1:0]    collide;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] sb [$];

  tank_disp_ctrl #(.N_TANK(N), .PLAYER_SLOT_EN(1)) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_idx(upd_idx),
    .upd_x(upd_x),
    .upd_y(upd_y),
    .upd_dir(upd_dir),
    .upd_state(upd_state),
    .tank_x_o(tank_x_o),
    .tank_y_o(tank_y_o),
    .tank_dir_o(tank_dir_o),
    .tank_state_o(tank_state_o),
    .tank_ide_o(tank_ide_o),
    .pix_en_i(pix_en_i),
    .pix_data_i(pix_data_i),
    .VGA_data(VGA_data),
    .VGA_en(VGA_en),
`ifdef TANK_COLLIDE_EN
    .collide(collide),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [4:0] x,
                    input logic [4:0] y, input logic [1:0] dir,
                    input logic st);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_x     = x;
    upd_y     = y;
    upd_dir   = dir;
    upd_state = st;
  endtask

  logic [3:0]  en_tbl  [6] = '{4'b0110, 4'b0000, 4'b1111,
                               4'b1000, 4'b0100, 4'b0001};
  logic [11:0] dat_tbl [6] = '{12'h00F, 12'h000, 12'hABC,
                               12'h123, 12'hF00, 12'hABC};
  logic        ven_tbl [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    logic [12:0] e;
    rst = 1'b1;
    frame_tick = 1'b0;
    upd_valid = 1'b0;
    upd_idx = '0;
    upd_x = '0;
    upd_y = '0;
    upd_dir = '0;
    upd_state = 1'b0;
    pix_en_i = '0;
    pix_data_i = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", 32'(tank_state_o), 0);
    chk("rst_x", 32'(tank_x_o), 0);
    chk("rst_ready", 32'(upd_ready), 1);
    chk("rst_vga_en", 32'(VGA_en), 0);
    chk("rst_vga_data", 32'(VGA_data), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("ide", 32'(tank_ide_o), 32'b0001);

    wr(2'd1, 5'd3, 5'd5, 2'b10, 1'b1);
    tick();
    upd_valid = 1'b0;
    tick();
    tick();
    chk("s1_pre_x", 32'(tank_x_o[9:5]), 0);
    chk("s1_pre_st", 32'(tank_state_o), 0);

    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("c1_rdy_T", 32'(upd_ready), 0);
    tick();
    chk("c1_rdy_T1", 32'(upd_ready), 0);
    chk("c1_s1_T1", 32'(tank_x_o[9:5]), 0);
    tick();
    chk("c1_s1_x", 32'(tank_x_o[9:5]), 3);
    chk("c1_s1_y", 32'(tank_y_o[9:5]), 5);
    chk("c1_s1_dir", 32'(tank_dir_o[3:2]), 2);
    chk("c1_st", 32'(tank_state_o), 32'b0010);
    chk("c1_rdy_T2", 32'(upd_ready), 0);
    tick();
    chk("c1_rdy_T3", 32'(upd_ready), 0);
    tick();
    chk("c1_rdy_T4", 32'(upd_ready), 1);

    wr(2'd2, 5'd4, 5'd1, 2'b11, 1'b1);
    tick();
    upd_x = 5'd9;
    tick();
    upd_valid = 1'b0;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    wr(2'd3, 5'd17, 5'd2, 2'b01, 1'b1);
    tick();
    tick();
    tick();
    chk("c2_s2_x", 32'(tank_x_o[14:10]), 9);
    chk("c2_s2_y", 32'(tank_y_o[14:10]), 1);
    chk("c2_rdy_T3", 32'(upd_ready), 0);
    tick();
    chk("c2_rdy_T4", 32'(upd_ready), 1);
    chk("c2_s3_held", 32'(tank_state_o[3]), 0);
    tick();
    upd_valid = 1'b0;
    chk("c2_s3_stg", 32'(tank_state_o[3]), 0);

    frame_tick = 1'b1;
    wr(2'd0, 5'd7, 5'd0, 2'b00, 1'b1);
    tick();
    frame_tick = 1'b0;
    upd_valid = 1'b0;
    chk("c3_ovr_T", 32'(overrun), 0);
    tick();
    chk("c3_s0_x", 32'(tank_x_o[4:0]), 7);
    chk("c3_s0_st", 32'(tank_state_o[0]), 1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("c3_ovr_set", 32'(overrun), 1);
    tick();
    chk("c3_rdy_T3", 32'(upd_ready), 0);
    tick();
    chk("c3_rdy_T4", 32'(upd_ready), 1);
    chk("c3_s3_x", 32'(tank_x_o[19:15]), 17);
    chk("c3_s3_dir", 32'(tank_dir_o[7:6]), 1);
    chk("c3_st", 32'(tank_state_o), 32'b1111);
    tick();
    tick();
    tick();
    chk("ovr_sticky", 32'(overrun), 1);
    chk("rdy_idle", 32'(upd_ready), 1);

    pix_data_i = {12'h123, 12'hF00, 12'h00F, 12'hABC};
    for (int k = 0; k < 6; k++) begin
      pix_en_i = en_tbl[k];
      sb.push_back({ven_tbl[k], dat_tbl[k]});
      tick();
      e = sb.pop_front();
      chk($sformatf("pix_en_%0d", k), 32'(VGA_en), 32'(e[12]));
      chk($sformatf("pix_data_%0d", k), 32'(VGA_data), 32'(e[11:0]));
    end
    pix_en_i = '0;

`ifdef TANK_COLLIDE_EN
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    pix_en_i = 4'b1001;
    tick();
    pix_en_i = '0;
    tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("collide_1001", 32'(collide), 32'b1001);
    for (int k = 0; k < 5; k++) tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("collide_clr", 32'(collide), 0);
    for (int k = 0; k < 5; k++) tick();
`endif

    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rdy", 32'(upd_ready), 1);
    chk("mid_rst_ovr", 32'(overrun), 0);
    chk("mid_rst_st", 32'(tank_state_o), 0);
    chk("mid_rst_x", 32'(tank_x_o), 0);
    tick();
    chk("mid_rst_idle", 32'(upd_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
